video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 720p sync generator.
//  Timings and sync polarity are set by parameters. Adds a pixel-clock enable,
//  frame-aligned run/stop control, and SOF/SOL strobes.
//  Sits between the pixel clock domain and the pixel source/VGA-to-HDMI encoder.
//  All outputs are registered and mutually aligned.
// PARAMETERS
//  H_SYNC    40    hsync width, pixels
//  H_BP      220   horizontal back porch, pixels
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch, pixels
//  V_SYNC    5     vsync width, lines
//  V_BP      20    vertical back porch, lines
//  V_ACTIVE  720   active lines
//  V_FP      5     vertical front porch, lines
//  HS_POL    0     asserted level of hsync (0 = active-low)
//  VS_POL    0     asserted level of vsync
//  CNT_W     12    counter/address width; H_TOTAL and V_TOTAL must be <= 2**CNT_W
// PORTS
//  clk        in   1      pixel clock
//  rst        in   1      synchronous, active-high reset
//  pix_en     in   1      pixel enable; state advances only on cycles with pix_en=1
//  run        in   1      level; request to generate frames
//  busy       out  1      1 while in RUN or DRAIN
//  hsync      out  1      horizontal sync, polarity HS_POL
//  vsync      out  1      vertical sync, polarity VS_POL
//  de         out  1      data enable, active region
//  sof        out  1      1-enabled-cycle strobe at h=0, v=0
//  sol        out  1      1-enabled-cycle strobe at h=0 of every line
//  col_addr   out  CNT_W  active column; 0 when de=0
//  row_addr   out  CNT_W  active row; 0 when de=0
// BEHAVIOUR
//  - Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order: sync, back porch, active, front porch.
//  - Counters h_cnt and v_cnt:
//    - h wraps H_TOTAL-1 -> 0.
//    - v increments only when h wraps, and wraps V_TOTAL-1 -> 0 only on that same h wrap.
//    - v never changes mid-line.
//  - Decode of (h,v), registered. Outputs reflect the counter value of the previous enabled cycle (latency 1).
//    - hsync = HS_POL when h < H_SYNC.
//    - vsync = VS_POL when v < V_SYNC.
//    - de when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE, and the same for v.
//    - col_addr = h-(H_SYNC+H_BP) and row_addr = v-(V_SYNC+V_BP) when de; else 0.
//  - FSM IDLE / RUN / DRAIN. Transitions are evaluated only on enabled cycles.
//    - IDLE: counters held at 0. hsync=~HS_POL, vsync=~VS_POL, de=sof=sol=0. When run=1, go to RUN; the next enabled cycle emits sof.
//    - RUN: counters free-run. If run=0, go to DRAIN.
//    - DRAIN: finish the current frame. At the last pixel (h=H_TOTAL-1, v=V_TOTAL-1), go to IDLE. If run=1 again before that, go back to RUN with no frame break.
//  - pix_en=0: counters, FSM and all outputs hold their values; strobes are not repeated.
//  - Reset (any time, including mid-frame): FSM=IDLE, counters=0, hsync=~HS_POL, vsync=~VS_POL, de=sof=sol=busy=0, col/row=0.
// STRUCTURE
//  - Shared package vid_timing_pkg: timing record/localparams for 720p60, 1080p60 and 480p60; the state enum {IDLE,RUN,DRAIN}.
//  - One sub-module, vid_axis_cnt: a wrap counter with enable and wrap flag, instantiated once for H and once for V (V enable = H wrap).
//  - Top: FSM plus registered decode.
// TESTING
//  - Reset, then run=1, pix_en=1, defaults:
//    - sof 1 cycle; hsync low for cycles 1-40, high at 41.
//    - First de at h=260, v=25 with col=0, row=0; last de with col=1279, row=719.
//    - Next sof exactly 1650*750 cycles after the first.
//  - H_ACTIVE=8, all porches/syncs=2, V likewise, HS_POL=VS_POL=1:
//    - hsync high for 2 cycles per 14-cycle line; 8 de cycles per line; 8 de lines per frame.
//  - pix_en toggled 1,0,1,0 during RUN: outputs identical to the run with pix_en=1 after removing the disabled cycles; sof/sol never doubled.
//  - run dropped mid-frame at v=100: frame completes; busy falls after h=1649, v=749; outputs idle.
//  - Run re-asserted during DRAIN: no gap; next sof at 1650*750.
//  - rst pulsed at h=700, v=300: next cycle idle outputs and counters 0; with run held at 1, restarts with sof.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// Shared types for the raster timing generator: controller state encoding and
// standard video mode timing records.
package vid_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vtg_state_t;

    typedef struct packed {
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        int unsigned v_active;
        int unsigned v_fp;
    } vid_timing_t;

    localparam vid_timing_t TIMING_720P60  = '{40, 220, 1280, 110, 5, 20, 720, 5};
    localparam vid_timing_t TIMING_1080P60 = '{44, 148, 1920, 88, 5, 36, 1080, 4};
    localparam vid_timing_t TIMING_480P60  = '{96, 48, 640, 16, 2, 33, 480, 10};

    function automatic int unsigned h_total(vid_timing_t t);
        return t.h_sync + t.h_bp + t.h_active + t.h_fp;
    endfunction

    function automatic int unsigned v_total(vid_timing_t t);
        return t.v_sync + t.v_bp + t.v_active + t.v_fp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Registered raster output bundle from the timing generator to the pixel
// source / encoder.
interface video_timing_gen_if #(
    parameter int CNT_W = 12
) ();
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             sof;
    logic             sol;
    logic [CNT_W-1:0] col_addr;
    logic [CNT_W-1:0] row_addr;

    modport master (output hsync, vsync, de, sof, sol, col_addr, row_addr);
    modport slave  (input  hsync, vsync, de, sof, sol, col_addr, row_addr);
endinterface

// File: rtl/vid_axis_cnt.sv
// Wrap counter for one raster axis: counts 0..LAST on enabled cycles and
// flags the enabled cycle on which it wraps back to 0.
module vid_axis_cnt #(
    parameter int CNT_W = 12,
    parameter int LAST  = 1649
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

    assign wrap = en && (cnt == LAST_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel-clock enable and
// frame-aligned run/stop control.
//   state | meaning
//   IDLE  | counters parked at 0, idle output levels
//   RUN   | frames generated back to back
//   DRAIN | run dropped; current frame is finished before returning to IDLE
module video_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_SYNC   = TIMING_720P60.h_sync,
    parameter int H_BP     = TIMING_720P60.h_bp,
    parameter int H_ACTIVE = TIMING_720P60.h_active,
    parameter int H_FP     = TIMING_720P60.h_fp,
    parameter int V_SYNC   = TIMING_720P60.v_sync,
    parameter int V_BP     = TIMING_720P60.v_bp,
    parameter int V_ACTIVE = TIMING_720P60.v_active,
    parameter int V_FP     = TIMING_720P60.v_fp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               run,
    output logic               busy,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_FIRST = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_FIRST = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    vtg_state_t       state, state_nxt;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             cnt_en, h_wrap, v_wrap, gen;
    logic             hsync_d, vsync_d, de_d, sof_d, sol_d;
    logic [CNT_W-1:0] col_d, row_d;

    assign gen    = (state != IDLE);
    assign cnt_en = pix_en && gen;

    vid_axis_cnt #(.CNT_W(CNT_W), .LAST(H_TOTAL - 1)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    vid_axis_cnt #(.CNT_W(CNT_W), .LAST(V_TOTAL - 1)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hsync_d   = ~HS_POL;
        vsync_d   = ~VS_POL;
        de_d      = 1'b0;
        sof_d     = 1'b0;
        sol_d     = 1'b0;
        col_d     = '0;
        row_d     = '0;

        // v_wrap is only ever true on an enabled cycle, so DRAIN exits at the last pixel.
        if (pix_en) begin
            unique case (state)
                IDLE:    if (run) state_nxt = RUN;
                RUN:     if (!run) state_nxt = DRAIN;
                DRAIN: begin
                    if (run)         state_nxt = RUN;
                    else if (v_wrap) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (gen) begin
            if (h_cnt < H_SYNC_C) hsync_d = HS_POL;
            if (v_cnt < V_SYNC_C) vsync_d = VS_POL;
            sol_d = (h_cnt == '0);
            sof_d = (h_cnt == '0) && (v_cnt == '0);
            de_d  = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST) &&
                    (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
            if (de_d) begin
                col_d = h_cnt - H_ACT_FIRST;
                row_d = v_cnt - V_ACT_FIRST;
            end
        end
    end

    // busy is registered with the decode so it rises with sof and falls after the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.hsync    <= ~HS_POL;
            vid.vsync    <= ~VS_POL;
            vid.de       <= 1'b0;
            vid.sof      <= 1'b0;
            vid.sol      <= 1'b0;
            vid.col_addr <= '0;
            vid.row_addr <= '0;
            busy         <= 1'b0;
        end else if (pix_en) begin
            vid.hsync    <= hsync_d;
            vid.vsync    <= vsync_d;
            vid.de       <= de_d;
            vid.sof      <= sof_d;
            vid.sol      <= sol_d;
            vid.col_addr <= col_d;
            vid.row_addr <= row_d;
            busy         <= gen;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 720p instance plus a tiny 14x14 raster
// instance for whole-frame, pix_en, drain and reset sequences.
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        sof;
        logic        sol;
        logic        busy;
        logic [11:0] col;
        logic [11:0] row;
    } obs_t;

    typedef struct packed {
        logic rst;
        logic run;
        logic en;
        obs_t exp;
    } vec_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic run    = 1'b0;
    logic pix_en = 1'b1;
    logic busy_a, busy_b;

    int n_pass  = 0;
    int n_total = 0;

    video_timing_gen_if #(.CNT_W(12)) a_if ();
    video_timing_gen_if #(.CNT_W(12)) b_if ();

    video_timing_gen dut_a (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .run    (run),
        .busy   (busy_a),
        .vid    (a_if)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(8), .V_FP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .run    (run),
        .busy   (busy_b),
        .vid    (b_if)
    );

    always #5 clk = ~clk;

    obs_t act_a, act_b;
    assign act_a = {a_if.hsync, a_if.vsync, a_if.de, a_if.sof, a_if.sol, busy_a,
                    a_if.col_addr, a_if.row_addr};
    assign act_b = {b_if.hsync, b_if.vsync, b_if.de, b_if.sof, b_if.sol, busy_b,
                    b_if.col_addr, b_if.row_addr};

    // Expected outputs for the pixel at (h,v), or idle levels when gen=0.
    function automatic obs_t exp_obs(bit gen, int h, int v, int hs_w, int hbp, int hact,
                                     int vs_w, int vbp, int vact, bit hpol, bit vpol);
        obs_t o;
        o    = '0;
        o.hs = ~hpol;
        o.vs = ~vpol;
        if (gen) begin
            o.busy = 1'b1;
            if (h < hs_w) o.hs = hpol;
            if (v < vs_w) o.vs = vpol;
            o.sol = (h == 0);
            o.sof = (h == 0) && (v == 0);
            if (h >= hs_w + hbp && h < hs_w + hbp + hact &&
                v >= vs_w + vbp && v < vs_w + vbp + vact) begin
                o.de  = 1'b1;
                o.col = 12'(h - hs_w - hbp);
                o.row = 12'(v - vs_w - vbp);
            end
        end
        return o;
    endfunction

    function automatic obs_t exp_a(bit gen, int h, int v);
        return exp_obs(gen, h, v, 40, 220, 1280, 5, 20, 720, 1'b0, 1'b0);
    endfunction

    function automatic obs_t exp_b(bit gen, int h, int v);
        return exp_obs(gen, h, v, 2, 2, 8, 2, 2, 8, 1'b1, 1'b1);
    endfunction

    function automatic vec_t mk(int r, int rn, int e, int hs, int vs, int de,
                                int sof, int sol, int bz, int col, int row);
        vec_t t;
        t.rst      = r[0];
        t.run      = rn[0];
        t.en       = e[0];
        t.exp.hs   = hs[0];
        t.exp.vs   = vs[0];
        t.exp.de   = de[0];
        t.exp.sof  = sof[0];
        t.exp.sol  = sol[0];
        t.exp.busy = bz[0];
        t.exp.col  = 12'(col);
        t.exp.row  = 12'(row);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got hs/vs/de/sof/sol/busy=%b%b%b%b%b%b col=%0d row=%0d, expected %b%b%b%b%b%b col=%0d row=%0d",
                     name, act.hs, act.vs, act.de, act.sof, act.sol, act.busy, act.col, act.row,
                     exp.hs, exp.vs, exp.de, exp.sof, exp.sol, exp.busy, exp.col, exp.row);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reset, then one IDLE cycle seeing run=1; the next step yields sof.
    task automatic start_b(input string name);
        rst    = 1'b1;
        run    = 1'b0;
        pix_en = 1'b1;
        step();
        check({name, "_rst"}, act_b, exp_b(0, 0, 0));
        rst = 1'b0;
        run = 1'b1;
        step();
        check({name, "_idle"}, act_b, exp_b(0, 0, 0));
    endtask

    vec_t vecs [14];

    initial begin
        int   j;
        int   expi;
        int   rises;
        int   sof_b;
        logic prev;

        // rst run en | hs vs de sof sol busy col row  (small instance, active-high syncs)
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 14; i++) begin
            rst    = vecs[i].rst;
            run    = vecs[i].run;
            pix_en = vecs[i].en;
            step();
            check($sformatf("vec%0d", i), act_b, vecs[i].exp);
        end

        // Default 720p instance through line 25 (first active pixel), small one in lockstep.
        rst    = 1'b1;
        run    = 1'b0;
        pix_en = 1'b1;
        step();
        check("a_rst", act_a, exp_a(0, 0, 0));
        check("b_rst", act_b, exp_b(0, 0, 0));
        rst = 1'b0;
        run = 1'b1;
        step();
        check("a_start_idle", act_a, exp_a(0, 0, 0));
        sof_b = 0;
        for (int k = 1; k <= 41600; k++) begin
            step();
            check("a_raster", act_a, exp_a(1, (k - 1) % 1650, (k - 1) / 1650));
            check("b_raster", act_b, exp_b(1, (k - 1) % 14, ((k - 1) / 14) % 14));
            if (k == 25 * 1650 + 261) begin
                check_int("a_first_de", int'(a_if.de), 1);
                check_int("a_first_col", int'(a_if.col_addr), 0);
                check_int("a_first_row", int'(a_if.row_addr), 0);
            end
            if (b_if.sof) sof_b++;
        end
        check_int("b_sof_count", sof_b, 213);

        // pix_en toggling 1,0,1,0: held outputs on disabled cycles, one sof per frame.
        start_b("p3");
        j     = 0;
        expi  = 0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 402; c++) begin
            pix_en = (c % 2 == 0);
            step();
            if (pix_en) begin
                expi = j;
                j++;
            end
            check("b_pix_en_toggle", act_b, exp_b(1, expi % 14, (expi / 14) % 14));
            if (act_b.sof && !prev) rises++;
            prev = act_b.sof;
        end
        pix_en = 1'b1;
        check_int("b_sof_not_doubled", rises, 2);

        // run dropped at v=6: frame completes, then idle with counters parked.
        start_b("p4");
        for (int k = 0; k < 196; k++) begin
            run = (k < 84);
            step();
            check("b_drain", act_b, exp_b(1, k % 14, k / 14));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_drain_idle", act_b, exp_b(0, 0, 0));
        end
        run = 1'b1;
        step();
        check("b_restart_idle", act_b, exp_b(0, 0, 0));
        step();
        check("b_restart_sof", act_b, exp_b(1, 0, 0));

        // run re-asserted during DRAIN: no frame break, next sof 196 cycles later.
        start_b("p5");
        for (int k = 0; k < 200; k++) begin
            run = !(k >= 50 && k < 60);
            step();
            check("b_rerun", act_b, exp_b(1, k % 14, (k / 14) % 14));
        end

        // rst pulsed at h=7, v=5 with run held high.
        start_b("p6");
        for (int k = 0; k < 77; k++) begin
            step();
            check("b_pre_rst", act_b, exp_b(1, k % 14, k / 14));
        end
        rst = 1'b1;
        step();
        check("b_rst_mid", act_b, exp_b(0, 0, 0));
        rst = 1'b0;
        step();
        check("b_rst_mid_idle", act_b, exp_b(0, 0, 0));
        step();
        check("b_rst_mid_sof", act_b, exp_b(1, 0, 0));
        step();
        check("b_rst_mid_h1", act_b, exp_b(1, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
